// File: rtl/vdc_pkg.sv
// Shared definitions for the van der Corput stream generator.
// Holds the controller state enum, the default parameter values and the
// helper functions that derive the base width (BW) and the shared divider
// width (DW) from the top-level parameters.
package vdc_pkg;

  localparam int DEF_K_WIDTH   = 32;
  localparam int DEF_FRAC_BITS = 32;
  localparam int DEF_MAX_BASE  = 16;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    EXTRACT,
    REVERSE,
    OUTPUT,
    ERR
  } state_t;

  // Bits needed to hold any base up to and including max_base.
  function automatic int calc_bw(input int max_base);
    return $clog2(max_base + 1);
  endfunction

  // The divider must cover both the digit-extraction dividend (an index k)
  // and the Horner numerator (V + d*2^FRAC_BITS, FRAC_BITS+BW bits).
  function automatic int calc_dw(input int k_width, input int frac_bits, input int bw);
    return (k_width > frac_bits + bw) ? k_width : frac_bits + bw;
  endfunction

endpackage

// File: rtl/vdc_serial_divider.sv
// Restoring radix-2 serial divider shared by digit extraction and Horner
// evaluation. A divide is requested by a one-cycle start pulse; the result
// is presented together with a one-cycle done pulse, so a divide occupies
// exactly DW+1 cycles from the start cycle to the cycle before done can be
// chained into the next start.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       load dividend/divisor and begin a divide
//   dividend    DW-bit unsigned dividend
//   divisor     BW-bit unsigned divisor (never zero when used)
//   busy        divide in progress
//   done        one-cycle pulse, quotient/remainder valid
//   quotient    DW-bit quotient
//   remainder   BW-bit remainder
module vdc_serial_divider
  import vdc_pkg::*;
#(
  parameter int BW = calc_bw(DEF_MAX_BASE),
  parameter int DW = calc_dw(DEF_K_WIDTH, DEF_FRAC_BITS, calc_bw(DEF_MAX_BASE))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [BW-1:0] remainder
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] quo_q;
  logic [BW-1:0] rem_q;
  logic [BW-1:0] dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [BW:0]   trial;
  logic          fits;

  // The partial remainder always stays below the divisor, so shifting in
  // one dividend bit needs only a single extra bit of headroom.
  always_comb begin
    trial = {rem_q, quo_q[DW-1]};
    fits  = (trial >= {1'b0, dvs_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quo_q  <= dividend;
        rem_q  <= '0;
        dvs_q  <= divisor;
        cnt_q  <= CW'(DW);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quo_q <= {quo_q[DW-2:0], fits};
        rem_q <= fits ? BW'(trial - {1'b0, dvs_q}) : trial[BW-1:0];
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/vdcorput_stream_gen.sv
// Streams exact van der Corput radical-inverse values for a burst of
// consecutive indices k, k+1, ... in a programmable base. Each value is
// computed by extracting base-b digits of k (LSD first, onto a stack) and
// then evaluating V <- floor((V + d*2^FRAC_BITS)/b) from the MSD down,
// all divides going through one shared serial divider.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_k                 first index of the burst
//   cmd_base              base, legal range 2..MAX_BASE
//   cmd_count             number of points, must be non-zero
//   out_valid/out_ready   result handshake
//   out_data              floor(vdc_b(k) * 2^FRAC_BITS)
//   out_k                 index belonging to out_data
//   out_last              final point of the burst
//   busy                  a command is being processed
//   err                   one-cycle pulse when a command is rejected
module vdcorput_stream_gen
  import vdc_pkg::*;
#(
  parameter int  K_WIDTH   = DEF_K_WIDTH,
  parameter int  FRAC_BITS = DEF_FRAC_BITS,
  parameter int  MAX_BASE  = DEF_MAX_BASE,
  parameter int  CNT_W     = DEF_CNT_W,
  localparam int BW        = calc_bw(MAX_BASE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [K_WIDTH-1:0]   cmd_k,
  input  logic [BW-1:0]        cmd_base,
  input  logic [CNT_W-1:0]     cmd_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAC_BITS-1:0] out_data,
  output logic [K_WIDTH-1:0]   out_k,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err
);

  localparam int DW  = calc_dw(K_WIDTH, FRAC_BITS, BW);
  localparam int SPW = $clog2(K_WIDTH + 1);
  localparam int SIW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

  state_t state_q, next_state;

  logic [BW-1:0]        base_q;
  logic [CNT_W-1:0]     remain_q;
  logic [K_WIDTH-1:0]   k_q;
  logic [K_WIDTH-1:0]   cur_q;
  logic [FRAC_BITS-1:0] acc_q;
  logic [SPW-1:0]       sp_q;
  logic [BW-1:0]        stack_q [K_WIDTH];

  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic          div_busy;
  logic          div_done;
  logic [DW-1:0] div_quo;
  logic [BW-1:0] div_rem;
  logic          div_active;

  logic           cmd_legal;
  logic           last_point;
  logic           do_accept;
  logic           do_push;
  logic           do_pop;
  logic           do_advance;
  logic [SIW-1:0] push_idx;
  logic [SIW-1:0] top_idx;
  logic [SIW-1:0] below_top_idx;

  assign cmd_legal  = (cmd_base >= BW'(2)) && (cmd_base <= BW'(MAX_BASE)) &&
                      (cmd_count != '0);
  assign last_point = (remain_q == CNT_W'(1));
  assign div_active = div_busy | div_done;

  assign push_idx      = SIW'(sp_q);
  assign top_idx       = SIW'(sp_q - SPW'(1));
  assign below_top_idx = SIW'(sp_q - SPW'(2));

  vdc_serial_divider #(
    .BW (BW),
    .DW (DW)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (base_q),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state and divider sequencing. When a divide finishes, the next one
  // is started in the same cycle using the freshly produced quotient (and,
  // while reversing, the digit below the one being popped), so consecutive
  // divides chain with no idle cycle between them.
  always_comb begin
    next_state   = state_q;
    div_start    = 1'b0;
    div_dividend = '0;
    do_accept    = 1'b0;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    do_advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          do_accept  = 1'b1;
          next_state = cmd_legal ? EXTRACT : ERR;
        end
      end
      EXTRACT: begin
        if (!div_active) begin
          if (cur_q == '0) begin
            next_state = REVERSE;
          end else begin
            div_start    = 1'b1;
            div_dividend = DW'(cur_q);
          end
        end else if (div_done) begin
          do_push = 1'b1;
          if (div_quo == '0) begin
            next_state = REVERSE;
          end else begin
            div_start    = 1'b1;
            div_dividend = div_quo;
          end
        end
      end
      REVERSE: begin
        if (!div_active) begin
          if (sp_q == '0) begin
            next_state = OUTPUT;
          end else begin
            div_start    = 1'b1;
            div_dividend = DW'({stack_q[top_idx], acc_q});
          end
        end else if (div_done) begin
          do_pop = 1'b1;
          if (sp_q == SPW'(1)) begin
            next_state = OUTPUT;
          end else begin
            div_start    = 1'b1;
            div_dividend = DW'({stack_q[below_top_idx], div_quo[FRAC_BITS-1:0]});
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          do_advance = 1'b1;
          next_state = last_point ? IDLE : EXTRACT;
        end
      end
      ERR: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Burst bookkeeping. Command fields are captured only on a legal accept,
  // so a rejected command leaves the previous results untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      remain_q <= '0;
      k_q      <= '0;
      cur_q    <= '0;
      acc_q    <= '0;
      sp_q     <= '0;
    end else begin
      if (do_accept && cmd_legal) begin
        base_q   <= cmd_base;
        remain_q <= cmd_count;
        k_q      <= cmd_k;
        cur_q    <= cmd_k;
        acc_q    <= '0;
        sp_q     <= '0;
      end
      if (do_push) begin
        sp_q  <= sp_q + SPW'(1);
        cur_q <= div_quo[K_WIDTH-1:0];
      end
      if (do_pop) begin
        sp_q  <= sp_q - SPW'(1);
        acc_q <= div_quo[FRAC_BITS-1:0];
      end
      if (do_advance && !last_point) begin
        remain_q <= remain_q - CNT_W'(1);
        k_q      <= k_q + K_WIDTH'(1);
        cur_q    <= k_q + K_WIDTH'(1);
        acc_q    <= '0;
      end
    end
  end

  // Digit storage needs no reset: only entries below the stack pointer are
  // ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_q[push_idx] <= div_rem;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign err       = (state_q == ERR);
  assign out_valid = (state_q == OUTPUT);
  assign out_last  = (state_q == OUTPUT) && last_point;
  assign out_data  = acc_q;
  assign out_k     = k_q;

endmodule
